// File: rtl/array_loader.sv
// Serial-to-parallel batch loader feeding the `array` weight bank, followed by
// REPEATS read-address sweeps over the captured batch.
module array_loader #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ADDR_W  = 2,
  parameter int unsigned REPEATS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WIDTH-1:0]  d [0:DEPTH-1],
  output logic [ADDR_W-1:0] address,
  output logic              sweep_valid,
  input  logic              sweep_ready,
  output logic              sweep_last,
  output logic              busy
);

  localparam int unsigned REP_W = $clog2(REPEATS + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [REP_W-1:0]  LAST_REP  = REP_W'(REPEATS - 1);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    SETTLE = 2'd1,
    SWEEP  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  wr_idx_q, wr_idx_d;
  logic [REP_W-1:0]   rep_cnt_q, rep_cnt_d;
  logic [ADDR_W-1:0]  address_q, address_d;
  logic [WIDTH-1:0]   d_q [0:DEPTH-1];
  logic [WIDTH-1:0]   d_d [0:DEPTH-1];
  logic               in_ready_q, in_ready_d;
  logic               sweep_valid_q, sweep_valid_d;
  logic               sweep_last_q, sweep_last_d;
  logic               busy_q, busy_d;
  logic               accept;
  logic               take;

  // Handshakes use the registered ready/valid flags, so no input reaches an output combinationally.
  assign accept = in_valid && in_ready_q;
  assign take   = sweep_valid_q && sweep_ready;

  always_comb begin
    state_d   = state_q;
    wr_idx_d  = wr_idx_q;
    rep_cnt_d = rep_cnt_q;
    address_d = address_q;
    d_d       = d_q;

    case (state_q)
      FILL: begin
        if (accept) begin
          d_d[wr_idx_q] = in_data;
          if (wr_idx_q == LAST_ADDR) begin
            wr_idx_d = '0;
            state_d  = SETTLE;
          end else begin
            wr_idx_d = wr_idx_q + ADDR_W'(1);
          end
        end
      end
      SETTLE: begin
        state_d   = SWEEP;
        address_d = '0;
        rep_cnt_d = '0;
      end
      SWEEP: begin
        if (take) begin
          if (address_q != LAST_ADDR) begin
            address_d = address_q + ADDR_W'(1);
          end else begin
            address_d = '0;
            rep_cnt_d = rep_cnt_q + REP_W'(1);
            if (rep_cnt_q == LAST_REP) state_d = FILL;
          end
        end
      end
      default: state_d = FILL;
    endcase

    // Output flags are decoded from the next state so they line up with it once registered.
    in_ready_d    = (state_d == FILL);
    sweep_valid_d = (state_d == SWEEP);
    busy_d        = (state_d != FILL);
    sweep_last_d  = (state_d == SWEEP) && (address_d == LAST_ADDR) && (rep_cnt_d == LAST_REP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= FILL;
      wr_idx_q      <= '0;
      rep_cnt_q     <= '0;
      address_q     <= '0;
      d_q           <= '{default: '0};
      in_ready_q    <= 1'b0;
      sweep_valid_q <= 1'b0;
      sweep_last_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_idx_q      <= wr_idx_d;
      rep_cnt_q     <= rep_cnt_d;
      address_q     <= address_d;
      d_q           <= d_d;
      in_ready_q    <= in_ready_d;
      sweep_valid_q <= sweep_valid_d;
      sweep_last_q  <= sweep_last_d;
      busy_q        <= busy_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign d           = d_q;
  assign address     = address_q;
  assign sweep_valid = sweep_valid_q;
  assign sweep_last  = sweep_last_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_array_loader.sv
// Scoreboard bench for array_loader: accepted words update a reference batch,
// completed batches queue their expected sweep, and sweep handshakes pop it.
module tb_array_loader;
  localparam int WIDTH = 16, DEPTH = 4, ADDR_W = 2, REPEATS = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [WIDTH-1:0]  in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  d [0:DEPTH-1];
  logic [ADDR_W-1:0] address;
  logic              sweep_valid;
  logic              sweep_ready = 1'b0;
  logic              sweep_last;
  logic              busy;

  array_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .REPEATS(REPEATS)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .d(d), .address(address), .sweep_valid(sweep_valid), .sweep_ready(sweep_ready),
    .sweep_last(sweep_last), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [WIDTH-1:0]  v;
    logic              l;
  } exp_t;

  exp_t       sb[$];
  logic [WIDTH-1:0] mdl_d [0:DEPTH-1];
  int         widx = 0;
  int         n_cmp = 0, n_bad = 0;
  logic       tk, acc;
  exp_t       obs, e;

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) mdl_d[i] = '0;
    widx = 0;
    sb.delete();
  endtask

  // One clock cycle: drive inputs, note handshakes seen by the DUT at the coming edge.
  task automatic step(input logic v, input logic [WIDTH-1:0] w, input logic sr);
    in_valid = v; in_data = w; sweep_ready = sr;
    tk  = sweep_valid && sr && rst_n;
    acc = in_ready && v && rst_n;
    obs = {address, d[address], sweep_last};
    if (acc) begin
      mdl_d[widx] = w;
      if (widx == DEPTH - 1) begin
        widx = 0;
        for (int r = 0; r < REPEATS; r++)
          for (int a = 0; a < DEPTH; a++)
            sb.push_back({ADDR_W'(a), mdl_d[a], 1'((r == REPEATS - 1) && (a == DEPTH - 1))});
      end else begin
        widx++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic ok;
    rst_n = 1'b0;
    repeat (3) step(1'b0, '0, 1'b0);
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (sweep_valid !== 1'b0) begin n_bad++; $display("FAIL rst_sweep_valid: got %b want 0", sweep_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (sweep_last !== 1'b0) begin n_bad++; $display("FAIL rst_sweep_last: got %b want 0", sweep_last); end
    n_cmp++; if (address !== '0) begin n_bad++; $display("FAIL rst_address: got %0d want 0", address); end
    ok = 1'b1;
    for (int i = 0; i < DEPTH; i++) if (d[i] !== 16'h0000) ok = 1'b0;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rst_d: got %h %h %h %h want all 0000", d[0], d[1], d[2], d[3]); end
    model_clear();
    rst_n = 1'b1;
    step(1'b0, '0, 1'b0);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] w [0:DEPTH-1];
    int k = 0, n_pre = 0, n_sw = 0, n_last = 0, last_pos = 0;
    logic done = 1'b0, ok = 1'b1;
    w[0] = 16'hff10; w[1] = 16'hcbff; w[2] = 16'hebff; w[3] = 16'habff;
    for (int c = 0; c < 20 && k < DEPTH; c++) begin step(1'b1, w[k], 1'b1); if (acc) k++; end
    in_valid = 1'b0;
    n_cmp++; if (k != DEPTH) begin n_bad++; $display("FAIL basic_fill_timeout: got %0d words want %0d", k, DEPTH); end
    for (int i = 0; i < DEPTH; i++) if (d[i] !== w[i]) ok = 1'b0;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL basic_d: got %h %h %h %h want ff10 cbff ebff abff", d[0], d[1], d[2], d[3]); end
    n_cmp++; if ({in_ready, sweep_valid, busy} !== 3'b001) begin
      n_bad++; $display("FAIL basic_settle: got ready/valid/busy=%b%b%b want 001", in_ready, sweep_valid, busy); end
    for (int c = 0; c < 40 && !done; c++) begin
      if (!sweep_valid && n_sw == 0) n_pre++;
      if (sweep_last) begin n_last++; last_pos = n_sw + 1; end
      if (sweep_valid) n_sw++;
      step(1'b0, '0, 1'b1);
      if (tk) begin
        n_cmp++;
        if (sb.size() == 0) begin n_bad++; $display("FAIL basic_sweep: handshake at addr %0d, none expected", obs.a); end
        else begin
          e = sb.pop_front();
          if (obs !== e) begin n_bad++; $display("FAIL basic_sweep: got a=%0d v=%h last=%b want a=%0d v=%h last=%b", obs.a, obs.v, obs.l, e.a, e.v, e.l); end
        end
      end
      done = tk && obs.l;
    end
    n_cmp++; if (n_pre != 1) begin n_bad++; $display("FAIL basic_settle_len: got %0d want 1", n_pre); end
    n_cmp++; if (n_sw != 8) begin n_bad++; $display("FAIL basic_sweep_len: got %0d want 8", n_sw); end
    n_cmp++; if (n_last != 1 || last_pos != 8) begin n_bad++; $display("FAIL basic_last: got count %0d pos %0d want 1 at 8", n_last, last_pos); end
    n_cmp++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL basic_refill: got ready %b busy %b want 1 0", in_ready, busy); end
  endtask

  task automatic test_bubbles();
    logic [WIDTH-1:0] w [0:DEPTH-1];
    int k = 0, hs = 0, stall = 0, n_sw = 0, n_at2 = 0;
    logic v, sr, done = 1'b0, ok = 1'b1;
    w[0] = 16'h0a01; w[1] = 16'h0a02; w[2] = 16'h0a03; w[3] = 16'h0a04;
    for (int c = 0; c < 20 && sb.size() == 0; c++) begin
      v = (c % 2 == 0);
      step(v, v ? w[k] : 16'hdead, 1'b1);
      if (acc) k++;
    end
    in_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) if (d[i] !== w[i]) ok = 1'b0;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL bubble_d: got %h %h %h %h want 0a01 0a02 0a03 0a04", d[0], d[1], d[2], d[3]); end
    for (int c = 0; c < 40 && !done; c++) begin
      sr = 1'b1;
      if (sweep_valid && hs == 2 && stall < 2) begin sr = 1'b0; stall++; end
      if (sweep_valid) n_sw++;
      if (sweep_valid && hs < DEPTH && address == 2'd2) n_at2++;
      step(1'b0, '0, sr);
      if (tk) begin
        hs++;
        n_cmp++;
        if (sb.size() == 0) begin n_bad++; $display("FAIL bubble_sweep: handshake at addr %0d, none expected", obs.a); end
        else begin
          e = sb.pop_front();
          if (obs !== e) begin n_bad++; $display("FAIL bubble_sweep: got a=%0d v=%h last=%b want a=%0d v=%h last=%b", obs.a, obs.v, obs.l, e.a, e.v, e.l); end
        end
      end
      done = tk && obs.l;
    end
    n_cmp++; if (n_at2 != 3) begin n_bad++; $display("FAIL bubble_hold: got %0d cycles at addr 2 want 3", n_at2); end
    n_cmp++; if (n_sw != 10) begin n_bad++; $display("FAIL bubble_sweep_len: got %0d want 10", n_sw); end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] w [0:7];
    int k = 0, n_lasts = 0;
    logic stall_ok = 1'b1, ok = 1'b1;
    for (int i = 0; i < 8; i++) w[i] = 16'hb001 + 16'(i);
    for (int c = 0; c < 80 && n_lasts < 2; c++) begin
      if (sweep_valid && n_lasts == 0 && (in_ready !== 1'b0 || k != DEPTH)) stall_ok = 1'b0;
      step(k < 8, (k < 8) ? w[k] : 16'h0000, 1'b1);
      if (acc) k++;
      if (tk) begin
        n_cmp++;
        if (sb.size() == 0) begin n_bad++; $display("FAIL b2b_sweep: handshake at addr %0d, none expected", obs.a); end
        else begin
          e = sb.pop_front();
          if (obs !== e) begin n_bad++; $display("FAIL b2b_sweep: got a=%0d v=%h last=%b want a=%0d v=%h last=%b", obs.a, obs.v, obs.l, e.a, e.v, e.l); end
        end
        if (obs.l) n_lasts++;
      end
    end
    in_valid = 1'b0;
    n_cmp++; if (!stall_ok) begin n_bad++; $display("FAIL b2b_stall: got words accepted during first sweep, want stalled at 4"); end
    n_cmp++; if (k != 8 || n_lasts != 2) begin n_bad++; $display("FAIL b2b_done: got %0d words %0d sweeps want 8 2", k, n_lasts); end
    for (int i = 0; i < DEPTH; i++) if (d[i] !== w[i+4]) ok = 1'b0;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_d: got %h %h %h %h want b005 b006 b007 b008", d[0], d[1], d[2], d[3]); end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] w [0:DEPTH-1];
    int k = 0;
    logic done = 1'b0, rdy_ok = 1'b1, d_ok = 1'b1, ok = 1'b1;
    w[0] = 16'hc001; w[1] = 16'hc002; w[2] = 16'hc003; w[3] = 16'hc004;
    for (int c = 0; c < 20 && sb.size() == 0; c++) begin step(1'b1, w[k], 1'b1); if (acc) k++; end
    for (int c = 0; c < 40 && !done; c++) begin
      if (sweep_valid && in_ready !== 1'b0) rdy_ok = 1'b0;
      for (int i = 0; i < DEPTH; i++) if (d[i] !== w[i]) d_ok = 1'b0;
      step(1'b1, 16'h1234, 1'b1);
      if (tk) begin
        n_cmp++;
        if (sb.size() == 0) begin n_bad++; $display("FAIL bp_sweep: handshake at addr %0d, none expected", obs.a); end
        else begin
          e = sb.pop_front();
          if (obs !== e) begin n_bad++; $display("FAIL bp_sweep: got a=%0d v=%h last=%b want a=%0d v=%h last=%b", obs.a, obs.v, obs.l, e.a, e.v, e.l); end
        end
      end
      done = tk && obs.l;
    end
    n_cmp++; if (!rdy_ok) begin n_bad++; $display("FAIL bp_in_ready: got in_ready=1 during sweep want 0"); end
    n_cmp++; if (!d_ok) begin n_bad++; $display("FAIL bp_d_hold: got d changed during sweep want c001..c004"); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_first_fill: got in_ready %b want 1", in_ready); end
    step(1'b1, 16'h1234, 1'b0);
    in_valid = 1'b0;
    if (d[0] !== 16'h1234) ok = 1'b0;
    for (int i = 1; i < DEPTH; i++) if (d[i] !== w[i]) ok = 1'b0;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL bp_land: got %h %h %h %h want 1234 c002 c003 c004", d[0], d[1], d[2], d[3]); end
  endtask

  task automatic test_reset_mid();
    int k = 0, hs = 0;
    logic ok = 1'b1, done = 1'b0;
    for (int c = 0; c < 20 && sb.size() == 0; c++) begin step(1'b1, 16'he001 + 16'(k), 1'b1); if (acc) k++; end
    for (int c = 0; c < 40 && !(sweep_valid && hs == 5); c++) begin
      step(1'b0, '0, 1'b1);
      if (tk) begin
        hs++;
        n_cmp++;
        if (sb.size() == 0) begin n_bad++; $display("FAIL mid_sweep: handshake at addr %0d, none expected", obs.a); end
        else begin
          e = sb.pop_front();
          if (obs !== e) begin n_bad++; $display("FAIL mid_sweep: got a=%0d v=%h last=%b want a=%0d v=%h last=%b", obs.a, obs.v, obs.l, e.a, e.v, e.l); end
        end
      end
    end
    n_cmp++; if (address !== 2'd1 || hs != 5) begin n_bad++; $display("FAIL mid_position: got addr %0d after %0d handshakes want 1 after 5", address, hs); end
    rst_n = 1'b0;
    step(1'b0, '0, 1'b0);
    for (int i = 0; i < DEPTH; i++) if (d[i] !== '0) ok = 1'b0;
    n_cmp++; if ({busy, sweep_valid, sweep_last, in_ready} !== 4'b0000 || address !== '0 || !ok) begin
      n_bad++; $display("FAIL mid_reset: got busy/valid/last/ready=%b%b%b%b addr %0d d0 %h want 0000 0 0000",
                        busy, sweep_valid, sweep_last, in_ready, address, d[0]); end
    rst_n = 1'b1;
    model_clear();
    k = 0;
    for (int c = 0; c < 20 && sb.size() == 0; c++) begin step(1'b1, 16'hf001 + 16'(k), 1'b1); if (acc) k++; end
    in_valid = 1'b0;
    hs = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      step(1'b0, '0, 1'b1);
      if (tk) begin
        hs++;
        n_cmp++;
        if (sb.size() == 0) begin n_bad++; $display("FAIL mid_reload: handshake at addr %0d, none expected", obs.a); end
        else begin
          e = sb.pop_front();
          if (obs !== e) begin n_bad++; $display("FAIL mid_reload: got a=%0d v=%h last=%b want a=%0d v=%h last=%b", obs.a, obs.v, obs.l, e.a, e.v, e.l); end
        end
      end
      done = tk && obs.l;
    end
    n_cmp++; if (hs != 8) begin n_bad++; $display("FAIL mid_reload_len: got %0d handshakes want 8", hs); end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic();
    test_bubbles();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
